// File: rtl/wptr_full_level_if.sv
// wptr_full_level_if: write-side FIFO pointer bus
// master drives the request/status inputs, slave (the pointer block) returns flags, address, pointer and level.
interface wptr_full_level_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   afull_thresh;
    logic                ovf_clr;
    logic                wfull;
    logic                awfull;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   wlevel;
    logic                wovf;
    modport master (
        output winc, wq2_rptr, afull_thresh, ovf_clr,
        input  wfull, awfull, waddr, wptr, wlevel, wovf
    );
    modport slave (
        input  winc, wq2_rptr, afull_thresh, ovf_clr,
        output wfull, awfull, waddr, wptr, wlevel, wovf
    );
endinterface

// File: rtl/wptr_full_level.sv
// wptr_full_level: async-FIFO write pointer with full, almost-full, fill level and optional sticky overflow
// Ports: wclk - write clock; wrst - async active-high reset;
//   bus.winc/wq2_rptr/afull_thresh/ovf_clr in, bus.wfull/awfull/waddr/wptr/wlevel/wovf out.
// Define WPTR_OVERFLOW_FLAG_EN to build the sticky overflow flag; otherwise wovf is tied low.
module wptr_full_level #(
    parameter int ADDRSIZE = 4
) (
    input logic               wclk,
    input logic               wrst,
    wptr_full_level_if.slave  bus
);
    localparam int W = ADDRSIZE + 1;
    logic [ADDRSIZE:0] r_wbin, r_wptr, r_wlevel;
    logic [ADDRSIZE:0] w_wbinnext, w_wgraynext, w_rbin, w_diff;
    logic              r_wfull, r_awfull, w_inc;
    assign w_inc       = bus.winc & ~r_wfull;
    assign w_wbinnext  = r_wbin + W'(w_inc);
    assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;
    // Gray to binary: each bit is the XOR of all Gray bits at and above it.
    for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_rbin
        assign w_rbin[i] = ^bus.wq2_rptr[ADDRSIZE:i];
    end
    assign w_diff = w_wbinnext - w_rbin;
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wbin   <= '0;
            r_wptr   <= '0;
            r_wfull  <= 1'b0;
            r_awfull <= 1'b0;
            r_wlevel <= '0;
        end else begin
            r_wbin   <= w_wbinnext;
            r_wptr   <= w_wgraynext;
            // Full when the next Gray write pointer equals the read pointer one lap ahead.
            r_wfull  <= w_wgraynext == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
            r_awfull <= w_diff >= bus.afull_thresh;
            r_wlevel <= w_diff;
        end
    end
`ifdef WPTR_OVERFLOW_FLAG_EN
    logic r_wovf;
    // A fresh overflow wins over a simultaneous clear.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) r_wovf <= 1'b0;
        else      r_wovf <= (bus.winc & r_wfull) ? 1'b1 : bus.ovf_clr ? 1'b0 : r_wovf;
    end
    assign bus.wovf = r_wovf;
`else
    assign bus.wovf = 1'b0;
`endif
    assign bus.wfull  = r_wfull;
    assign bus.awfull = r_awfull;
    assign bus.waddr  = r_wbin[ADDRSIZE-1:0];
    assign bus.wptr   = r_wptr;
    assign bus.wlevel = r_wlevel;
endmodule

// File: tb/tb_wptr_full_level.sv
// tb_wptr_full_level: directed plus random checks of wptr_full_level against a counting reference model
module tb_wptr_full_level;
`ifdef WPTR_OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    logic wclk = 1'b0;
    logic wrst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    // Reference model: plain binary counters, level is write count minus read count.
    int   m_wbin, m_rd, m_lvl, th;
    bit   m_full, m_aw, m_ovf;
    wptr_full_level_if #(.ADDRSIZE(4)) bus ();
    wptr_full_level #(.ADDRSIZE(4)) dut (.wclk(wclk), .wrst(wrst), .bus(bus.slave));
    always #5 wclk = ~wclk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_all();
        chk("wfull", 32'(bus.wfull), 32'(m_full));
        chk("awfull", 32'(bus.awfull), 32'(m_aw));
        chk("wlevel", 32'(bus.wlevel), 32'(m_lvl));
        chk("waddr", 32'(bus.waddr), 32'(m_wbin % 16));
        chk("wptr", 32'(bus.wptr), 32'(m_wbin ^ (m_wbin >> 1)));
        chk("wovf", 32'(bus.wovf), 32'(m_ovf));
    endtask
    // Called between edges; applies inputs, advances the model by one edge, checks after the edge.
    task automatic step(input bit inc, input bit clr);
        int nxt;
        int d;
        bus.winc = inc;
        bus.ovf_clr = clr;
        bus.wq2_rptr = 5'(m_rd ^ (m_rd >> 1));
        bus.afull_thresh = 5'(th);
        nxt = (m_wbin + int'(inc && !m_full)) % 32;
        d = (nxt - m_rd + 32) % 32;
        m_ovf = OVF_EN && ((inc && m_full) || (!clr && m_ovf));
        m_wbin = nxt;
        m_full = (d == 16);
        m_aw = (d >= th);
        m_lvl = d;
        @(posedge wclk);
        #1;
        check_all();
        @(negedge wclk);
    endtask
    task automatic model_reset();
        m_wbin = 0; m_rd = 0; m_lvl = 0;
        m_full = 0; m_aw = 0; m_ovf = 0;
    endtask
    task automatic do_reset();
        bus.winc = 0;
        bus.ovf_clr = 0;
        bus.wq2_rptr = '0;
        wrst = 1;
        #1;
        model_reset();
        check_all();
        #1;
        wrst = 0;
        step(0, 0);
    endtask
    initial begin
        th = 12;
        bus.afull_thresh = 5'd12;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 0);
            if (i == 10) chk("awfull_before_12", 32'(bus.awfull), 32'd0);
            if (i == 11) chk("awfull_at_12", 32'(bus.awfull), 32'd1);
        end
        chk("full16_wfull", 32'(bus.wfull), 32'd1);
        chk("full16_wlevel", 32'(bus.wlevel), 32'd16);
        chk("full16_wptr", 32'(bus.wptr), 32'b11000);
        chk("full16_waddr", 32'(bus.waddr), 32'd0);
        step(1, 0);
        chk("ovf_wptr_hold", 32'(bus.wptr), 32'b11000);
        chk("ovf_waddr_hold", 32'(bus.waddr), 32'd0);
        chk("ovf_set", 32'(bus.wovf), 32'(OVF_EN));
        step(0, 1);
        chk("ovf_clr", 32'(bus.wovf), 32'd0);
        step(1, 1);
        chk("ovf_set_and_clr", 32'(bus.wovf), 32'(OVF_EN));
        step(0, 1);
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 0);
        chk("af12_awfull", 32'(bus.awfull), 32'd1);
        chk("af12_wlevel", 32'(bus.wlevel), 32'd12);
        m_rd = 4;
        step(0, 0);
        chk("rd4_gray", 32'(bus.wq2_rptr), 32'b00110);
        chk("rd4_wlevel", 32'(bus.wlevel), 32'd8);
        chk("rd4_awfull", 32'(bus.awfull), 32'd0);
        m_rd = 12;
        for (int i = 0; i < 4; i++) step(1, 0);
        m_rd = 16;
        step(0, 0);
        chk("rd16_gray", 32'(bus.wq2_rptr), 32'b11000);
        for (int i = 0; i < 16; i++) step(1, 0);
        chk("wrap_wptr", 32'(bus.wptr), 32'd0);
        chk("wrap_waddr", 32'(bus.waddr), 32'd0);
        chk("wrap_wfull", 32'(bus.wfull), 32'd1);
        chk("wrap_wlevel", 32'(bus.wlevel), 32'd16);
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 3 == 0) m_rd = (m_rd + int'($urandom_range(0, m_lvl))) % 32;
            if ($urandom % 50 == 0) th = int'($urandom_range(0, 20));
            step($urandom % 4 != 0, $urandom % 8 == 0);
        end
        th = 12;
        for (int i = 0; i < 40 && !m_full; i++) step(1, 0);
        step(1, 0);
        chk("pre_rst_wfull", 32'(bus.wfull), 32'd1);
        chk("pre_rst_wovf", 32'(bus.wovf), 32'(OVF_EN));
        bus.winc = 0;
        bus.ovf_clr = 0;
        #2;
        wrst = 1;
        #1;
        model_reset();
        bus.wq2_rptr = '0;
        chk("arst_wfull", 32'(bus.wfull), 32'd0);
        chk("arst_wovf", 32'(bus.wovf), 32'd0);
        check_all();
        #1;
        wrst = 0;
        step(0, 0);
        step(1, 0);
        chk("resume_waddr", 32'(bus.waddr), 32'd1);
        chk("resume_wlevel", 32'(bus.wlevel), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/wptr_full_level.md
WPTR_FULL_LEVEL -- requirements
Module: wptr_full_level

Interface
REQ-001 SHALL have parameter: ADDRSIZE, 4, FIFO address width; depth = 2^ADDRSIZE; legal range >= 2.
REQ-002 SHALL have port: wclk  input  1  write-domain clock; single clock, all logic on rising edge.
REQ-003 SHALL have port: wrst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: winc  input  1  write request; honoured only while wfull=0.
REQ-005 SHALL have port: wq2_rptr  input  ADDRSIZE+1  read pointer, Gray-coded, already synchronized into wclk.
REQ-006 SHALL have port: afull_thresh  input  ADDRSIZE+1  almost-full level threshold, unsigned, quasi-static.
REQ-007 SHALL have port: ovf_clr  input  1  clears sticky overflow flag.
REQ-008 SHALL have port: wfull  output  1  FIFO full, registered.
REQ-009 SHALL have port: awfull  output  1  almost full, registered.
REQ-010 SHALL have port: waddr  output  ADDRSIZE  memory write address = low ADDRSIZE bits of binary write pointer.
REQ-011 SHALL have port: wptr  output  ADDRSIZE+1  Gray write pointer, registered, for synchronization into the read domain.
REQ-012 SHALL have port: wlevel  output  ADDRSIZE+1  fill level seen from write side, registered, 0..2^ADDRSIZE.
REQ-013 SHALL have port: wovf  output  1  sticky overflow flag.

Function
REQ-014 SHALL hold internal binary pointer wbin (ADDRSIZE+1 bits); wbinnext = wbin + (winc & ~wfull), modulo 2^(ADDRSIZE+1).
REQ-015 SHALL compute wgraynext = (wbinnext >> 1) XOR wbinnext; wbin <= wbinnext and wptr <= wgraynext on every edge.
REQ-016 SHALL drive waddr combinationally from registered wbin; a write at edge N uses the waddr present before edge N.
REQ-017 SHALL register wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}); wfull rises on the same edge as the write that fills the FIFO.
REQ-018 SHALL ignore winc while wfull=1: wbin, wptr, waddr unchanged.
REQ-019 SHALL convert wq2_rptr to binary rbin_s combinationally (prefix XOR from MSB down).
REQ-020 SHALL register wlevel <= (wbinnext - rbin_s) modulo 2^(ADDRSIZE+1); no extra latency beyond one edge.
REQ-021 SHALL register awfull <= ((wbinnext - rbin_s) >= afull_thresh), unsigned compare; afull_thresh=0 forces awfull=1 after first edge out of reset; afull_thresh > 2^ADDRSIZE never asserts.
REQ-022 SHALL deassert wfull/awfull one edge after wq2_rptr advances enough to drop the level; no combinational path from wq2_rptr to outputs.
REQ-023 SHALL handle pointer wrap (wbin 2^(ADDRSIZE+1)-1 -> 0) with correct full, level and Gray sequence.
REQ-024 SHALL set wovf on the edge following a cycle with winc=1 and wfull=1; ovf_clr=1 clears it; set and clear in same cycle -> wovf=1.

Reset
REQ-025 SHALL, while wrst=1, force wbin=0, wptr=0, waddr=0, wfull=0, awfull=0, wlevel=0, wovf=0 immediately, without waiting for a clock edge.
REQ-026 SHALL restart counting from zero on first wclk edge after wrst deasserts; reset mid-operation discards all write history.

Configuration
REQ-027 SHALL compile overflow detection in only when macro WPTR_OVERFLOW_FLAG_EN is defined: behaviour per REQ-024.
REQ-028 SHALL, without WPTR_OVERFLOW_FLAG_EN, tie wovf to 0, ignore ovf_clr, and instantiate no overflow register; all other behaviour identical.

Verification (ADDRSIZE=4, depth 16)
REQ-029 SHALL check: reset, wq2_rptr=0, 16 consecutive winc -> wfull=1 at 16th write edge, wlevel=16, wptr=5'b11000, waddr=0.
REQ-030 SHALL check: 17th winc while full -> wptr/waddr unchanged; wovf=1 next edge (macro on) or 0 (macro off); ovf_clr=1 -> wovf=0; ovf_clr with new overflow same cycle -> wovf stays 1.
REQ-031 SHALL check: afull_thresh=12, writes from empty -> awfull rises at 12th write edge; then wq2_rptr=5'b00110 (bin 4) -> wlevel=8, awfull=0 one edge later.
REQ-032 SHALL check: wq2_rptr=5'b11000 (bin 16), wbin=16, 16 more writes -> wbin wraps to 0, wptr=0, wfull=1, wlevel=16.
REQ-033 SHALL check: wrst pulsed asynchronously between edges while wfull=1, wovf=1 -> all outputs 0 before next wclk edge, counting resumes from 0 after release.
